core_v_mcu_timer: RTL

CORE_V_MCU_TIMER -- requirements
Module: core_v_mcu_timer

---
 rtl/core_v_mcu_timer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/core_v_mcu_timer.sv
// core_v_mcu_timer: machine timer with a prescaler, a 64-bit mtime and a 64-bit
// compare. It exposes a zero-wait-state register port and a level interrupt.
// The request and response structs are handled as flat packed vectors.
// Request layout, MSB first: addr[31:0], write, wdata[31:0], wstrb[3:0], valid.
// Response layout, MSB first: rdata[31:0], error, ready.
module core_v_mcu_timer #(
    parameter type         reg_req_t = logic,
    parameter type         reg_rsp_t = logic,
    parameter int unsigned PrescW    = 16
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output logic     time_irq_o
);

    localparam int ReqW = 70;
    localparam int RspW = 34;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESC    = 3'd1;
    localparam logic [2:0] ADDR_MTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_MTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_CMP_LO   = 3'd4;
    localparam logic [2:0] ADDR_CMP_HI   = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    logic [ReqW-1:0]   req_bits;
    logic [RspW-1:0]   rsp_bits;
    logic [2:0]        req_idx;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              req_valid;
    logic              unused_req_bits;

    logic [1:0]        ctrl_q, ctrl_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [PrescW-1:0] cnt_q, cnt_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       cmp_q, cmp_d;
    logic              irq_q, irq_d;

    logic [31:0]       rd_word;
    logic [31:0]       wr_word;
    logic              pend;
    logic              tick;
    logic              req_error;
    logic              wr_en;

    assign req_bits        = ReqW'(reg_req_i);
    assign req_idx         = req_bits[42:40];
    assign req_write       = req_bits[37];
    assign req_wdata       = req_bits[36:5];
    assign req_wstrb       = req_bits[4:1];
    assign req_valid       = req_bits[0];
    assign unused_req_bits = ^{req_bits[69:43], req_bits[39:38]};

    assign pend      = (mtime_q >= cmp_q);
    assign tick      = ctrl_q[0] && (cnt_q == presc_q);
    assign req_error = req_valid && ((req_idx == 3'd7) || (req_write && (req_idx == ADDR_STATUS)));
    assign wr_en     = req_valid && req_write && !req_error;

    // Merge the enabled write bytes onto the current register contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    // Register read mux; unused CTRL/PRESC bits and unmapped slots read as zero.
    always_comb begin
        rd_word = '0;
        case (req_idx)
            ADDR_CTRL:     rd_word = {30'd0, ctrl_q};
            ADDR_PRESC:    rd_word = 32'(presc_q);
            ADDR_MTIME_LO: rd_word = mtime_q[31:0];
            ADDR_MTIME_HI: rd_word = mtime_q[63:32];
            ADDR_CMP_LO:   rd_word = cmp_q[31:0];
            ADDR_CMP_HI:   rd_word = cmp_q[63:32];
            ADDR_STATUS:   rd_word = {31'd0, pend};
            default:       rd_word = '0;
        endcase
    end

    assign wr_word = merge_bytes(rd_word, req_wdata, req_wstrb);

    // Response is silent while reset is held, otherwise answers in the same cycle.
    assign rsp_bits  = rst_i ? '0 : {rd_word, req_error, req_valid};
    assign reg_rsp_o = reg_rsp_t'(rsp_bits);

    // Next-state: prescaler and mtime advance, then bus writes override the tick.
    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        irq_d   = pend & ctrl_q[1];

        if (ctrl_q[0]) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_en) begin
            case (req_idx)
                ADDR_CTRL: begin
                    ctrl_d = wr_word[1:0];
                    cnt_d  = '0;
                end
                ADDR_PRESC: begin
                    presc_d = wr_word[PrescW-1:0];
                    cnt_d   = '0;
                end
                ADDR_MTIME_LO: mtime_d = {mtime_q[63:32], wr_word};
                ADDR_MTIME_HI: mtime_d = {wr_word, mtime_q[31:0]};
                ADDR_CMP_LO:   cmp_d   = {cmp_q[63:32], wr_word};
                ADDR_CMP_HI:   cmp_d   = {wr_word, cmp_q[31:0]};
                default: ;
            endcase
        end
    end

    // State registers with asynchronous reset to the idle, disabled timer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            mtime_q <= '0;
            cmp_q   <= '1;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign time_irq_o = irq_q;

endmodule
